// File: rtl/uart_row_loader_if.sv
// uart_row_loader_if: groups the UART receive strobe and the framebuffer
// write / status signals of uart_row_loader into one bundle.
// master: drives received bytes (UART side / bench); slave: the loader itself.
interface uart_row_loader_if #(
  parameter int ROW_ADDR_WIDTH = 5,
  parameter int COL_ADDR_WIDTH = 6
);
  logic [7:0]                             rx_data;
  logic                                   rx_data_valid;
  logic                                   wr_en;
  logic [ROW_ADDR_WIDTH+COL_ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]                            wr_data;
  logic                                   frame_swap;
  logic                                   busy;
  logic                                   cmd_done;
  logic                                   cmd_error;

  modport master (
    output rx_data, rx_data_valid,
    input  wr_en, wr_addr, wr_data, frame_swap, busy, cmd_done, cmd_error
  );

  modport slave (
    input  rx_data, rx_data_valid,
    output wr_en, wr_addr, wr_data, frame_swap, busy, cmd_done, cmd_error
  );
endinterface

// File: rtl/uart_row_loader.sv
// uart_row_loader: parses "L <row> <pixel pairs>" row loads and "S" frame
// swaps from a UART byte stream and drives the framebuffer write port.
// Optional feature: define UART_ROW_LOADER_TIMEOUT_EN to abort a command
// whose inter-byte gap reaches TIMEOUT_TICKS cycles; without it a stalled
// command waits indefinitely.
module uart_row_loader #(
  parameter int          PIXELS_PER_ROW = 64,
  parameter int          COL_ADDR_WIDTH = 6,
  parameter int          ROW_ADDR_WIDTH = 5,
  parameter logic [15:0] TIMEOUT_TICKS  = 16'd4000,
  parameter int          TIMEOUT_WIDTH  = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  uart_row_loader_if.slave bus
);

  localparam int AW = ROW_ADDR_WIDTH + COL_ADDR_WIDTH;
  localparam logic [COL_ADDR_WIDTH-1:0] LAST_COL = COL_ADDR_WIDTH'(PIXELS_PER_ROW - 1);
  localparam logic [31:0] ROW_COUNT = 32'(2 ** ROW_ADDR_WIDTH);

  localparam logic [7:0] OP_LOAD = 8'h4C;
  localparam logic [7:0] OP_SWAP = 8'h53;

  typedef enum logic [1:0] {IDLE, ROW, PIX_HI, PIX_LO} state_e;

  state_e                    state_q, state_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [COL_ADDR_WIDTH-1:0] col_q, col_d;
  logic [7:0]                hi_q, hi_d;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic          frame_swap_q, frame_swap_d;
  logic          busy_q, busy_d;
  logic          cmd_done_q, cmd_done_d;
  logic          cmd_error_q, cmd_error_d;

  logic          timeout_hit;

`ifdef UART_ROW_LOADER_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;

  // Inter-byte gap counter: idle in IDLE, cleared by every accepted byte.
  always_comb begin
    if (state_q == IDLE || bus.rx_data_valid || timeout_hit) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // A byte arriving in the expiry cycle wins over the abort.
  assign timeout_hit = (state_q != IDLE) && !bus.rx_data_valid &&
                       (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_TICKS - 16'd1));

  // Gap counter register.
  always_ff @(posedge clk_in) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and registered-output decode for the command parser.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    hi_d         = hi_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_swap_d = 1'b0;
    cmd_done_d   = 1'b0;
    cmd_error_d  = 1'b0;

    if (timeout_hit) begin
      cmd_error_d = 1'b1;
      state_d     = IDLE;
    end else if (bus.rx_data_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == OP_LOAD) begin
            state_d = ROW;
          end else if (bus.rx_data == OP_SWAP) begin
            frame_swap_d = 1'b1;
          end else begin
            cmd_error_d = 1'b1;
          end
        end
        ROW: begin
          if ({24'd0, bus.rx_data} < ROW_COUNT) begin
            row_d   = ROW_ADDR_WIDTH'(bus.rx_data);
            col_d   = '0;
            state_d = PIX_HI;
          end else begin
            cmd_error_d = 1'b1;
            state_d     = IDLE;
          end
        end
        PIX_HI: begin
          hi_d    = bus.rx_data;
          state_d = PIX_LO;
        end
        PIX_LO: begin
          wr_en_d   = 1'b1;
          wr_addr_d = {row_q, col_q};
          wr_data_d = {hi_q, bus.rx_data};
          if (col_q == LAST_COL) begin
            cmd_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = PIX_HI;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers; reset dominates any input byte.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      hi_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_swap_q <= 1'b0;
      busy_q       <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      hi_q         <= hi_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_swap_q <= frame_swap_d;
      busy_q       <= busy_d;
      cmd_done_q   <= cmd_done_d;
      cmd_error_q  <= cmd_error_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_swap = frame_swap_q;
  assign bus.busy       = busy_q;
  assign bus.cmd_done   = cmd_done_q;
  assign bus.cmd_error  = cmd_error_q;

endmodule

// File: tb/tb_uart_row_loader.sv
// tb_uart_row_loader: directed bench for uart_row_loader. TIMEOUT_TICKS is
// set to 15; the timeout scenario expects an abort only when
// UART_ROW_LOADER_TIMEOUT_EN is defined.
module tb_uart_row_loader;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_in = ~clk_in;

  uart_row_loader_if bus ();

  uart_row_loader #(
    .TIMEOUT_TICKS (16'd15)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Activity monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [10:0] wq_addr[$];
  logic [15:0] wq_data[$];
  int          n_done, n_swap, n_err, err_cyc;
  logic        done_wr;
  logic [10:0] done_addr;

  always @(posedge clk_in) cyc++;

  always @(negedge clk_in) begin
    if (bus.wr_en === 1'b1) begin
      wq_addr.push_back(bus.wr_addr);
      wq_data.push_back(bus.wr_data);
    end
    if (bus.cmd_done === 1'b1) begin
      n_done++;
      done_wr   = bus.wr_en;
      done_addr = bus.wr_addr;
    end
    if (bus.frame_swap === 1'b1) n_swap++;
    if (bus.cmd_error === 1'b1) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    n_done = 0; n_swap = 0; n_err = 0; err_cyc = -1;
    done_wr = 1'b0; done_addr = '0;
  endtask

  // Present one byte for exactly one rising edge; returns 1 time unit after it.
  task automatic send(input logic [7:0] b);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    @(posedge clk_in); #1;
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.rx_data_valid = 1'b0;
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  // Row load command; pixel i = base + (inc ? i : 0); gap idle cycles after each byte.
  task automatic send_row(input logic [7:0] row, input logic [15:0] base,
                          input bit inc, input int gap, input int npix);
    logic [15:0] p;
    send(8'h4C); idle(gap);
    send(row);   idle(gap);
    for (int i = 0; i < npix; i++) begin
      p = inc ? base + 16'(i) : base;
      send(p[15:8]); idle(gap);
      send(p[7:0]);  idle(gap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rx_data = 8'h4C;
    bus.rx_data_valid = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    cmp_cnt++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_swap, bus.busy,
         bus.cmd_done, bus.cmd_error} !== 33'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h swap=%b busy=%b done=%b err=%b, want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_swap, bus.busy, bus.cmd_done, bus.cmd_error);
    end
    bus.rx_data_valid = 1'b0;
    reset = 1'b0;
    idle(1);
    cmp_cnt++;
    if (bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ignores_rx: busy=%b, want 0", bus.busy);
    end
  endtask

  task automatic test_full_row();
    int bad = 0;
    clear_mon();
    send(8'h4C);
    cmp_cnt++;
    if (bus.busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL busy_after_L: busy=%b, want 1", bus.busy);
    end
    idle(1);
    send(8'h04); idle(1);
    for (int i = 0; i < 64; i++) begin
      send(8'h12); idle(1);
      send(8'(i)); idle(1);
    end
    idle(2);
    cmp_cnt++;
    if (wq_addr.size() !== 64) begin
      err_cnt++;
      $display("FAIL full_row_count: got %0d writes, want 64", wq_addr.size());
    end
    for (int i = 0; i < 64 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 11'h100 + 11'(i) || wq_data[i] !== 16'h1200 + 16'(i)) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL full_row_data: %0d writes with wrong addr/data, want 0", bad);
    end
    cmp_cnt++;
    if (n_done !== 1 || done_wr !== 1'b1 || done_addr !== 11'h13F) begin
      err_cnt++;
      $display("FAIL full_row_done: done=%0d with_wr=%b addr=%h, want 1/1/13f", n_done, done_wr, done_addr);
    end
    cmp_cnt++;
    if (bus.busy !== 1'b0 || n_err !== 0) begin
      err_cnt++;
      $display("FAIL full_row_end: busy=%b err=%0d, want 0/0", bus.busy, n_err);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    clear_mon();
    send_row(8'h05, 16'h1200, 1'b1, 0, 64);
    send(8'h53);
    idle(3);
    cmp_cnt++;
    if (wq_addr.size() !== 64) begin
      err_cnt++;
      $display("FAIL b2b_count: got %0d writes, want 64", wq_addr.size());
    end
    for (int i = 0; i < 64 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 11'h140 + 11'(i) || wq_data[i] !== 16'h1200 + 16'(i)) bad++;
    end
    cmp_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL b2b_data: %0d writes with wrong addr/data, want 0", bad);
    end
    cmp_cnt++;
    if (n_swap !== 1 || n_done !== 1 || n_err !== 0) begin
      err_cnt++;
      $display("FAIL b2b_pulses: swap=%0d done=%0d err=%0d, want 1/1/0", n_swap, n_done, n_err);
    end
  endtask

  task automatic test_bad_row();
    int bad = 0;
    clear_mon();
    send(8'h4C);
    send(8'h20);
    idle(2);
    cmp_cnt++;
    if (n_err !== 1 || wq_addr.size() !== 0 || bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL bad_row: err=%0d writes=%0d busy=%b, want 1/0/0", n_err, wq_addr.size(), bus.busy);
    end
    send_row(8'h00, 16'hA000, 1'b1, 0, 64);
    idle(2);
    for (int i = 0; i < 64 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 11'(i) || wq_data[i] !== 16'hA000 + 16'(i)) bad++;
    end
    cmp_cnt++;
    if (wq_addr.size() !== 64 || bad != 0 || n_done !== 1 || n_err !== 1) begin
      err_cnt++;
      $display("FAIL row0_after_bad: writes=%0d bad=%0d done=%0d err=%0d, want 64/0/1/1",
               wq_addr.size(), bad, n_done, n_err);
    end
  endtask

  task automatic test_opcode_data();
    int bad = 0;
    clear_mon();
    send_row(8'h07, 16'h4C53, 1'b0, 0, 64);
    idle(2);
    for (int i = 0; i < 64 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 11'h1C0 + 11'(i) || wq_data[i] !== 16'h4C53) bad++;
    end
    cmp_cnt++;
    if (wq_addr.size() !== 64 || bad != 0) begin
      err_cnt++;
      $display("FAIL opcode_data_writes: writes=%0d bad=%0d, want 64/0", wq_addr.size(), bad);
    end
    cmp_cnt++;
    if (n_swap !== 0 || n_err !== 0 || n_done !== 1) begin
      err_cnt++;
      $display("FAIL opcode_data_pulses: swap=%0d err=%0d done=%0d, want 0/0/1", n_swap, n_err, n_done);
    end
    clear_mon();
    send(8'h99);
    cmp_cnt++;
    if (bus.cmd_error !== 1'b1 || bus.busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL stray_byte: cmd_error=%b busy=%b, want 1/0", bus.cmd_error, bus.busy);
    end
    idle(2);
    cmp_cnt++;
    if (n_err !== 1) begin
      err_cnt++;
      $display("FAIL stray_byte_count: err=%0d, want 1", n_err);
    end
  endtask

  task automatic test_timeout();
    int e;
    clear_mon();
    send(8'h4C);
    send(8'h01);
    send(8'hAB);
    e = cyc;
    idle(20);
`ifdef UART_ROW_LOADER_TIMEOUT_EN
    cmp_cnt++;
    if (n_err !== 1 || err_cyc !== e + 15) begin
      err_cnt++;
      $display("FAIL timeout_error: err=%0d at cycle +%0d, want 1 at +15", n_err, err_cyc - e);
    end
    cmp_cnt++;
    if (bus.busy !== 1'b0 || wq_addr.size() !== 0) begin
      err_cnt++;
      $display("FAIL timeout_state: busy=%b writes=%0d, want 0/0", bus.busy, wq_addr.size());
    end
`else
    cmp_cnt++;
    if (n_err !== 0 || bus.busy !== 1'b1 || wq_addr.size() !== 0) begin
      err_cnt++;
      $display("FAIL stall_waits: err=%0d busy=%b writes=%0d, want 0/1/0", n_err, bus.busy, wq_addr.size());
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_row();
    int bad = 0;
    clear_mon();
    send_row(8'h03, 16'h3000, 1'b1, 0, 10);
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    cmp_cnt++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_swap, bus.busy,
         bus.cmd_done, bus.cmd_error} !== 33'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_outputs: wr_en=%b addr=%h data=%h busy=%b, want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy);
    end
    idle(2);
    cmp_cnt++;
    if (wq_addr.size() !== 10 || n_done !== 0 || n_err !== 0) begin
      err_cnt++;
      $display("FAIL reset_mid_pulses: writes=%0d done=%0d err=%0d, want 10/0/0", wq_addr.size(), n_done, n_err);
    end
    clear_mon();
    send_row(8'h03, 16'h3000, 1'b1, 0, 64);
    idle(2);
    for (int i = 0; i < 64 && i < wq_addr.size(); i++) begin
      if (wq_addr[i] !== 11'h0C0 + 11'(i) || wq_data[i] !== 16'h3000 + 16'(i)) bad++;
    end
    cmp_cnt++;
    if (wq_addr.size() !== 64 || bad != 0 || n_done !== 1) begin
      err_cnt++;
      $display("FAIL row3_after_reset: writes=%0d bad=%0d done=%0d, want 64/0/1", wq_addr.size(), bad, n_done);
    end
  endtask

  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_data_valid = 1'b0;
    clear_mon();
    test_reset();
    test_full_row();
    test_back_to_back();
    test_bad_row();
    test_opcode_data();
    test_timeout();
    test_reset_mid_row();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_row_loader.md
# uart_row_loader

Byte-stream command sequencer between the UART receiver and the display framebuffer write port. It parses `L <row> <pixel data>` row-load commands and `S` frame-swap commands from the RGB data UART. Each 16-bit pixel is assembled from two bytes and written into the framebuffer at `{row, column}`. Malformed or stalled commands are aborted so that the byte stream re-synchronises on the next opcode.

## Interface
Parameters:
- `PIXELS_PER_ROW`, 64, pixels carried by one `L` command.
- `COL_ADDR_WIDTH`, 6, column address bits; `2**COL_ADDR_WIDTH >= PIXELS_PER_ROW`.
- `ROW_ADDR_WIDTH`, 5, row address bits; legal rows are `0 .. 2**ROW_ADDR_WIDTH-1`.
- `TIMEOUT_TICKS`, 16'd4000, maximum allowed inter-byte gap in `clk_in` cycles inside a command.
- `TIMEOUT_WIDTH`, 5'd16, width of the timeout counter.

Ports:
- `clk_in`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high.
- `rx_data`, input, 8: received byte.
- `rx_data_valid`, input, 1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `wr_en`, output, 1: framebuffer write strobe.
- `wr_addr`, output, `ROW_ADDR_WIDTH+COL_ADDR_WIDTH`: `{row, col}`.
- `wr_data`, output, 16: pixel, `{hi_byte, lo_byte}`.
- `frame_swap`, output, 1: one-cycle pulse requesting a buffer swap.
- `busy`, output, 1: high while a command is in progress (any state except IDLE).
- `cmd_done`, output, 1: one-cycle pulse when a row completes.
- `cmd_error`, output, 1: one-cycle pulse on abort or when an unknown opcode is discarded.

## Operation
- States: IDLE, ROW, PIX_HI, PIX_LO.
- IDLE:
  - Byte 0x4C (`L`): go to ROW.
  - Byte 0x53 (`S`): pulse `frame_swap`; stay in IDLE.
  - Any other byte: pulse `cmd_error`; stay in IDLE.
- ROW:
  - Byte < `2**ROW_ADDR_WIDTH`: latch the row, clear `col` to 0, go to PIX_HI.
  - Otherwise: pulse `cmd_error`, go to IDLE.
- PIX_HI: latch the byte as `hi`; go to PIX_LO.
- PIX_LO: on a byte, issue one write: `wr_addr={row,col}`, `wr_data={hi,byte}`.
  - If `col == PIXELS_PER_ROW-1`: pulse `cmd_done`, go to IDLE.
  - Otherwise: increment `col`, go to PIX_HI.
- Byte values are only interpreted as opcodes in IDLE. 0x4C and 0x53 inside pixel data are data.
- `col` never wraps. Reaching `PIXELS_PER_ROW-1` always terminates the command.
- Every output is registered.
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `frame_swap=0`, `busy=0`, `cmd_done=0`, `cmd_error=0`, state IDLE.
- Reset mid-command: the partial row is abandoned. Pixels already written stay in the framebuffer. No `cmd_done` or `cmd_error` is emitted.

## Timing
- All state and outputs update on the rising edge of `clk_in`.
- Writes: byte accepted at edge N (`rx_data_valid=1` in cycle N). `wr_en`, `wr_addr` and `wr_data` are valid in cycle N+1 for exactly one cycle.
- `cmd_done` is asserted in the same cycle as the final `wr_en`.
- `frame_swap` and `cmd_error` pulse in cycle N+1 after the triggering byte.
- `busy` rises in cycle N+1 after the `L` byte. It falls in the same cycle as `cmd_done` or `cmd_error`.
- Back-to-back `rx_data_valid` (every cycle) must be accepted with no drops. Sustained write rate is one write per two bytes.
- `rx_data_valid` is ignored while `reset` is high.
- Minimum `L` command: 2 + 2·`PIXELS_PER_ROW` bytes; 130 bytes at the defaults.

## Configuration
- `UART_ROW_LOADER_TIMEOUT_EN` defined:
  - A `TIMEOUT_WIDTH`-bit counter runs while state != IDLE and clears on every accepted byte.
  - When it reaches `TIMEOUT_TICKS-1` with no byte in that cycle: pulse `cmd_error`, go to IDLE, no write.
  - If a byte arrives in the same cycle the counter reaches `TIMEOUT_TICKS-1`, the byte wins and the counter clears.
- Macro undefined:
  - No counter is implemented.
  - A stalled command waits indefinitely in its current state.

## Test plan
- Full row: send 0x4C, 0x04, then 64 pixel pairs with pixel i = 0x1200+i. Expect 64 `wr_en` pulses, `wr_addr` 0x100..0x13F, `wr_data` 0x1200..0x123F. `cmd_done` coincides with the write to 0x13F; `busy` is low afterwards.
- Back-to-back streaming: the above sent with `rx_data_valid` held high for 130 consecutive cycles, followed immediately by 0x53. Expect no dropped writes, then one `frame_swap` pulse.
- Bad row: send 0x4C, 0x20. Expect `cmd_error` pulse and no `wr_en`. A following 0x4C 0x00 + 128 bytes loads row 0 normally.
- Opcode bytes inside data: a row whose pixels are all 0x4C53. Expect 64 writes of 0x4C53 and no `frame_swap`. Separately, stray byte 0x99 in IDLE gives one `cmd_error`.
- Timeout (macro on, `TIMEOUT_TICKS=15`): send 0x4C, 0x01, 0xAB, then idle 20 cycles. Expect `cmd_error` in the 15th cycle after the last byte's edge, state IDLE, and no write. With the macro off: no error and `busy` stays high.
- Reset mid-row: assert `reset` for 1 cycle after 10 pixels of row 3. Expect all outputs 0 on the next edge with no `cmd_done`. A subsequent full row 3 completes with 64 writes.
